// File: rtl/node_link_arb.sv
// node_link_arb: multi-channel link interface between a router port and CH local clients.
// Egress round-robins client flits onto one credit-controlled link; ingress buffers
// incoming flits in a B-deep FIFO and steers the head flit to a client by its channel id.
// Optional build macro: NODE_LINK_CH0_PRIO_EN gives channel 0 strict egress priority.
module node_link_arb #(
    parameter int CH   = 4,
    parameter int B    = 4,
    parameter int FW   = 59,
    parameter int FTW  = 3,
    parameter int CIDW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    src_vld,
    input  logic [CH*FW-1:0] src_flit,
    output logic [CH-1:0]    src_rdy,
    input  logic             credit_in,
    output logic             flit_out_wr,
    output logic [FW-1:0]    flit_out,
    input  logic             flit_in_wr,
    input  logic [FW-1:0]    flit_in,
    output logic             credit_out,
    output logic [CH-1:0]    dst_vld,
    output logic [FW-1:0]    dst_flit,
    input  logic [CH-1:0]    dst_rdy,
    output logic             err
);

    localparam int CNTW = $clog2(B + 1);
    localparam int RRW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int AW   = (B > 1) ? $clog2(B) : 1;

    logic [CNTW-1:0] cnt;
    logic [RRW-1:0]  rr;
    logic            grant_vld;
    logic            grant_prio;
    logic [RRW-1:0]  grant_idx;
    logic [RRW:0]    scan_sum;
    logic [FW-1:0]   sel_flit;
    logic            credit_ovf;

    logic [FW-1:0]   mem [B];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            empty;
    logic            full;
    logic [FW-1:0]   head;
    logic [CIDW-1:0] cid;
    logic            cid_bad;
    logic            bad_seen;
    logic            bad_pop;
    logic            good_pop;
    logic            pop;
    logic            push;
    logic            push_drop;

    // Advance a {wrap, index} FIFO pointer, toggling the wrap bit at the last slot.
    function automatic logic [AW:0] next_ptr(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(B - 1))
            return {~p[AW], {AW{1'b0}}};
        else
            return p + 1'b1;
    endfunction

    // Pick the first requesting client at or after the round-robin pointer when credit is available.
    always_comb begin
        grant_vld  = 1'b0;
        grant_prio = 1'b0;
        grant_idx  = '0;
        scan_sum   = '0;
        if (cnt != '0) begin
`ifdef NODE_LINK_CH0_PRIO_EN
            if (src_vld[0]) begin
                grant_vld  = 1'b1;
                grant_prio = 1'b1;
            end
`endif
            for (int k = 0; k < CH; k++) begin
                scan_sum = {1'b0, rr} + (RRW + 1)'(k);
                if (scan_sum >= (RRW + 1)'(CH))
                    scan_sum = scan_sum - (RRW + 1)'(CH);
                if (!grant_vld && src_vld[scan_sum[RRW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_sum[RRW-1:0];
                end
            end
        end
    end

    // Decode the grant into the one-hot ready and select the granted client's flit.
    always_comb begin
        src_rdy  = '0;
        sel_flit = '0;
        if (grant_vld)
            src_rdy[grant_idx] = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (grant_idx == RRW'(i))
                sel_flit = src_flit[i*FW +: FW];
        end
    end

    assign credit_ovf = credit_in && !grant_vld && (cnt == CNTW'(B));

    // Egress state: credit count, round-robin pointer and the registered output flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= CNTW'(B);
            rr          <= '0;
            flit_out_wr <= 1'b0;
            flit_out    <= '0;
        end else begin
            flit_out_wr <= grant_vld;
            if (grant_vld)
                flit_out <= sel_flit;
            if (grant_vld && !grant_prio)
                rr <= (grant_idx == RRW'(CH - 1)) ? '0 : grant_idx + 1'b1;
            case ({credit_in, grant_vld})
                2'b10:   if (!credit_ovf) cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign cid      = head[FW-FTW-1 -: CIDW];
    assign dst_flit = head;
    assign cid_bad  = !empty && ({1'b0, cid} >= (CIDW + 1)'(CH));
    assign bad_pop  = cid_bad && bad_seen;

    // Steer the head flit to the client named by its channel id; unknown ids get no valid.
    always_comb begin
        dst_vld = '0;
        if (!empty) begin
            for (int i = 0; i < CH; i++) begin
                if ({1'b0, cid} == (CIDW + 1)'(i))
                    dst_vld[i] = 1'b1;
            end
        end
    end

    assign good_pop  = |(dst_vld & dst_rdy);
    assign pop       = good_pop || bad_pop;
    assign push      = flit_in_wr && (!full || pop);
    assign push_drop = flit_in_wr && full && !pop;

    // Ingress FIFO storage, pointers, bad-id drop timing and the credit return pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < B; i++)
                mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bad_seen   <= 1'b0;
            credit_out <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= flit_in;
                wr_ptr              <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            bad_seen   <= cid_bad && !bad_pop;
            credit_out <= pop;
        end
    end

    // Sticky error for credit overflow, pushes into a full FIFO and unknown channel ids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (credit_ovf || push_drop || bad_pop)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_node_link_arb.sv
// tb_node_link_arb: scoreboard bench for node_link_arb with a queue-based reference model.
// Honours NODE_LINK_CH0_PRIO_EN the same way as the design build.
module tb_node_link_arb;

    localparam int CH   = 4;
    localparam int B    = 4;
    localparam int FW   = 59;
    localparam int FTW  = 3;
    localparam int CIDW = 2;

    logic             clk;
    logic             rst_n;
    logic [CH-1:0]    src_vld;
    logic [CH*FW-1:0] src_flit;
    logic [CH-1:0]    src_rdy;
    logic             credit_in;
    logic             flit_out_wr;
    logic [FW-1:0]    flit_out;
    logic             flit_in_wr;
    logic [FW-1:0]    flit_in;
    logic             credit_out;
    logic [CH-1:0]    dst_vld;
    logic [FW-1:0]    dst_flit;
    logic [CH-1:0]    dst_rdy;
    logic             err;

    int checks = 0;
    int errors = 0;

    // Reference model state: credits, rr position, ingress contents, expected registered outputs.
    int            m_cnt;
    int            m_rr;
    logic [FW-1:0] m_fifo[$];
    logic [FW-1:0] egr_q[$];
    logic          m_err;
    logic          m_exp_wr;
    logic          m_exp_credit;

    node_link_arb #(.CH(CH), .B(B), .FW(FW), .FTW(FTW), .CIDW(CIDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_vld(src_vld), .src_flit(src_flit), .src_rdy(src_rdy),
        .credit_in(credit_in), .flit_out_wr(flit_out_wr), .flit_out(flit_out),
        .flit_in_wr(flit_in_wr), .flit_in(flit_in), .credit_out(credit_out),
        .dst_vld(dst_vld), .dst_flit(dst_flit), .dst_rdy(dst_rdy), .err(err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] randFlit();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[FW-1:0];
    endfunction

    function automatic logic [FW-1:0] mkFlit(input logic [CIDW-1:0] c);
        logic [FW-1:0] f;
        f = randFlit();
        f[FW-FTW-1 -: CIDW] = c;
        return f;
    endfunction

    // Egress monitor: every flit the DUT emits must match the oldest granted flit.
    always @(negedge clk) begin
        if (rst_n && flit_out_wr) begin
            if (egr_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL flit_out_extra: got strobe with flit %0h, expected no strobe", flit_out);
            end else begin
                checkOutput("flit_out", flit_out, egr_q.pop_front());
            end
        end
    end

    // Compare DUT against the model for this cycle, then advance the model past the coming edge.
    task automatic modelStep();
        int            g;
        logic [CH-1:0] exp_rdy;
        logic [CH-1:0] exp_dv;
        logic [CIDW-1:0] c;
        logic          pop;

        checkOutput("flit_out_wr", flit_out_wr, m_exp_wr);
        checkOutput("credit_out", credit_out, m_exp_credit);
        checkOutput("err", err, m_err);

        g = -1;
        if (m_cnt > 0) begin
`ifdef NODE_LINK_CH0_PRIO_EN
            if (src_vld[0]) g = 0;
`endif
            for (int k = 0; k < CH; k++) begin
                int idx;
                idx = (m_rr + k) % CH;
                if (g < 0 && src_vld[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checkOutput("src_rdy", src_rdy, exp_rdy);

        if (g >= 0) begin
            egr_q.push_back(src_flit[g*FW +: FW]);
`ifdef NODE_LINK_CH0_PRIO_EN
            if (g != 0) m_rr = (g + 1) % CH;
`else
            m_rr = (g + 1) % CH;
`endif
        end
        if (credit_in && m_cnt == B && g < 0)
            m_err = 1'b1;
        else
            m_cnt = m_cnt + int'(credit_in) - ((g >= 0) ? 1 : 0);
        m_exp_wr = (g >= 0);

        pop    = 1'b0;
        exp_dv = '0;
        if (m_fifo.size() > 0) begin
            c = m_fifo[0][FW-FTW-1 -: CIDW];
            exp_dv[c] = 1'b1;
            checkOutput("dst_flit", dst_flit, m_fifo[0]);
            pop = dst_rdy[c];
        end
        checkOutput("dst_vld", dst_vld, exp_dv);
        if (pop) void'(m_fifo.pop_front());
        if (flit_in_wr) begin
            if (m_fifo.size() == B) m_err = 1'b1;
            else m_fifo.push_back(flit_in);
        end
        m_exp_credit = pop;
    endtask

    // Drive one cycle of inputs just after the edge, then check at the falling edge.
    task automatic applyStimulus(input logic [CH-1:0] sv, input logic ci, input logic fwr,
                                 input logic [FW-1:0] fin, input logic [CH-1:0] dr);
        @(posedge clk);
        #1;
        src_vld    = sv;
        credit_in  = ci;
        flit_in_wr = fwr;
        flit_in    = fin;
        dst_rdy    = dr;
        for (int i = 0; i < CH; i++)
            src_flit[i*FW +: FW] = randFlit();
        @(negedge clk);
        modelStep();
    endtask

    // Assert reset, check all outputs idle, and restart the model.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        src_vld    = '0;
        src_flit   = '0;
        credit_in  = 1'b0;
        flit_in_wr = 1'b0;
        flit_in    = '0;
        dst_rdy    = '0;
        @(negedge clk);
        checkOutput("rst_flit_out_wr", flit_out_wr, 0);
        checkOutput("rst_flit_out", flit_out, 0);
        checkOutput("rst_credit_out", credit_out, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_src_rdy", src_rdy, 0);
        checkOutput("rst_dst_vld", dst_vld, 0);
        @(negedge clk);
        m_cnt        = B;
        m_rr         = 0;
        m_err        = 1'b0;
        m_exp_wr     = 1'b0;
        m_exp_credit = 1'b0;
        m_fifo.delete();
        egr_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b1;
        src_vld    = '0;
        src_flit   = '0;
        credit_in  = 1'b0;
        flit_in_wr = 1'b0;
        flit_in    = '0;
        dst_rdy    = '0;
        #1;
        doReset();

        // All four clients request with no returning credit: four grants then stall.
        for (int i = 0; i < 7; i++) applyStimulus(4'b1111, 1'b0, 1'b0, '0, '0);
        applyStimulus(4'b0000, 1'b0, 1'b0, '0, '0);

        // A single credit from empty allows exactly one send, one cycle later.
        applyStimulus(4'b0100, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 1'b0, 1'b0, '0, '0);
        applyStimulus(4'b0000, 1'b0, 1'b0, '0, '0);

        // Ingress steering by channel id with all clients ready.
        applyStimulus('0, 1'b0, 1'b1, mkFlit(2'd1), 4'b1111);
        applyStimulus('0, 1'b0, 1'b1, mkFlit(2'd3), 4'b1111);
        applyStimulus('0, 1'b0, 1'b1, mkFlit(2'd0), 4'b1111);
        applyStimulus('0, 1'b0, 1'b1, mkFlit(2'd2), 4'b1111);
        for (int i = 0; i < 4; i++) applyStimulus('0, 1'b0, 1'b0, '0, 4'b1111);

        // Overfill the ingress FIFO, then drain it.
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus('0, 1'b0, 1'b1, mkFlit(2'($urandom_range(0, 3))), 4'b0000);
        for (int i = 0; i < 6; i++) applyStimulus('0, 1'b0, 1'b0, '0, 4'b1111);

        // Credit return while the counter is already full.
        doReset();
        applyStimulus('0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 2; i++) applyStimulus('0, 1'b0, 1'b0, '0, '0);

        // Two contending clients with credits replenished every cycle.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(4'b0011, 1'b1, 1'b0, '0, '0);
        applyStimulus('0, 1'b0, 1'b0, '0, '0);

        // Random legal traffic on both directions.
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic ci;
            logic fwr;
            ci  = (m_cnt < B) && ($urandom_range(0, 2) != 0);
            fwr = (m_fifo.size() < B) && ($urandom_range(0, 1) == 1);
            applyStimulus(CH'($urandom_range(0, 15)), ci, fwr,
                          mkFlit(2'($urandom_range(0, 3))), CH'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 8; i++) applyStimulus('0, 1'b0, 1'b0, '0, 4'b1111);
        checkOutput("egress_drained", egr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/node_link_arb.md
Name: node_link_arb

Overview:
- Multi-channel link interface for the next-generation node. Sits between the router port and CH local clients (spk_out engines, config responder, ...).
- Egress: round-robins CH client flit sources onto one credit-controlled flit_out link.
- Ingress: buffers incoming flits in a B-deep FIFO and steers each one to a client by its channel-id field. Returns one credit per flit consumed.

Parameters:
- CH, 4, number of local client channels (2..8)
- B, 4, link buffer depth; equals upstream/downstream credit count
- FW, 59, flit width
- FTW, 3, flit type width (flit MSBs)
- CIDW, 2, channel-id width; clog2(CH); field at flit[FW-FTW-1 -: CIDW]

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- src_vld  in  CH  client i has a flit to send
- src_flit  in  CH*FW  client flits; client i at [i*FW +: FW]
- src_rdy  out  CH  one-hot grant; flit taken this cycle when src_vld[i]&src_rdy[i]
- credit_in  in  1  one-cycle pulse, downstream freed one slot
- flit_out_wr  out  1  flit_out valid strobe
- flit_out  out  FW  egress flit
- flit_in_wr  in  1  ingress flit strobe
- flit_in  in  FW  ingress flit
- credit_out  out  1  one-cycle pulse per ingress flit consumed
- dst_vld  out  CH  head flit valid for client i (at most one bit set)
- dst_flit  out  FW  ingress FIFO head flit, shared by all clients
- dst_rdy  in  CH  client i accepts head flit
- err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0; credit counter cnt=B; rr pointer=0; ingress FIFO empty; err=0.
- Egress credit counter cnt (width clog2(B+1)):
  - next cnt = cnt + credit_in − send.
  - No same-cycle bypass: a send requires cnt>0 at the start of the cycle.
- Egress arbitration:
  - If cnt>0 and any src_vld: grant g = first set src_vld at or after rr, wrapping at CH. src_rdy = onehot(g), combinational from src_vld, cnt and rr.
  - Otherwise src_rdy=0.
  - On a grant, rr <= (g+1) mod CH. rr does not change without a grant.
- Egress output:
  - flit_out and flit_out_wr are registered. A flit granted in cycle t appears with flit_out_wr=1 in cycle t+1.
  - flit_out holds its last value when flit_out_wr=0.
  - Throughput: one flit per cycle while credits last.
- Credit overflow: credit_in when cnt==B and no send in that cycle → cnt stays B, err<=1.
- Ingress FIFO:
  - Depth B, circular read/write pointers with a wrap bit.
  - flit_in_wr pushes flit_in.
  - Push into a full FIFO drops the flit and sets err<=1. This is an upstream credit violation.
  - Push and pop in the same cycle are both legal when full.
- Ingress steering:
  - cid = head[FW-FTW-1 -: CIDW]. dst_vld[cid] = !empty; dst_flit = head.
  - Pop when dst_vld[cid]&dst_rdy[cid]. dst_rdy bits for other channels are ignored.
  - A head flit with cid>=CH is popped automatically the cycle after it reaches the head, with no dst_vld, and sets err.
  - Head-of-line blocking is by design.
- credit_out: registered; a pop in cycle t gives credit_out=1 in cycle t+1. Exactly one pulse per pop, including dropped cid>=CH flits. A full-FIFO dropped push returns no credit.
- err clears only on reset.
- Reset mid-operation: in-flight flits are lost. cnt returns to B; the link partner must be reset together with this block.

Optional Feature:
- Macro: NODE_LINK_CH0_PRIO_EN.
- Defined: channel 0 has strict priority. If cnt>0 and src_vld[0]=1, grant 0 and leave rr unchanged. Channels 1..CH-1 round-robin as above among themselves when src_vld[0]=0.
- Undefined: all channels round-robin equally as specified above.

Test Plan:
- Reset, then src_vld=4'b1111 held, credit_in=0 → grants in order ch0,ch1,ch2,ch3 on consecutive cycles; then no grant; flit_out_wr pulses 4 cycles, each one cycle after its grant; cnt=0.
- From cnt=0, pulse credit_in once with src_vld=4'b0100 → grant to ch2 on the cycle after the pulse (no bypass); one flit_out_wr; cnt returns to 0.
- Push 4 ingress flits with cid=1,3,0,2, dst_rdy=4'b1111 → dst_vld follows 0010,1000,0001,0100 one per cycle; 4 credit_out pulses, each one cycle after its pop.
- Push 5 flits back-to-back with dst_rdy=0 → 5th flit dropped, err=1, FIFO holds the first 4; then dst_rdy=all ones → 4 pops and exactly 4 credit_out pulses.
- credit_in pulse at cnt=B with no send → cnt stays 4, err=1.
- With NODE_LINK_CH0_PRIO_EN defined and src_vld=4'b0011 held, credits ample → ch0 granted every cycle, ch1 never. With the macro undefined → grants alternate ch0,ch1.
